// File: rtl/i2s_master_pkg.sv
// Shared I2S frame geometry and helpers for the clock-master transceiver.
// The slot layout is right-justified: 8 pad bits then 24 data bits, MSB first.
package i2s_master_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int DATA_BITS  = 24;
  localparam int PAD_BITS   = 8;
  localparam int FRAME_BITS = 64;

  localparam int BIT_CNT_W = $clog2(FRAME_BITS);
  // Only bits that can still reach a data field by the frame end are kept in RX.
  localparam int RX_KEEP = FRAME_BITS - PAD_BITS - 1;

  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [DATA_BITS-1:0] l,
                                                       input logic [DATA_BITS-1:0] r);
    return {{PAD_BITS{1'b0}}, l, {PAD_BITS{1'b0}}, r};
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Generates MCLK, BCLK and LRCK plus single-cycle strobes marking the
// BCLK edges and the frame boundaries, all in the system clock domain.
module i2s_clkgen
  import i2s_master_pkg::*;
#(
  parameter int HALF_DIV  = 16,
  parameter int MCLK_LOG2 = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic mclk,
  output logic bclk,
  output logic lrck,
  output logic rise_stb,
  output logic fall_stb,
  output logic frame_start_stb,
  output logic frame_end_stb
);

  localparam int HC_W = $clog2(HALF_DIV);

  logic [HC_W-1:0]      hc_reg;
  logic                 bclk_reg;
  logic                 lrck_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_next;
  logic [MCLK_LOG2-1:0] mclk_cnt_reg;
  logic                 half_wrap;

  // Strobes fire in the cycle whose clock edge makes bclk toggle.
  assign half_wrap       = (hc_reg == HC_W'(HALF_DIV - 1));
  assign rise_stb        = half_wrap & ~bclk_reg;
  assign fall_stb        = half_wrap & bclk_reg;
  assign frame_start_stb = fall_stb & (bit_cnt_reg == '1);
  assign frame_end_stb   = rise_stb & (bit_cnt_reg == '1);
  assign bit_cnt_next    = bit_cnt_reg + 1'b1;

  assign mclk = mclk_cnt_reg[MCLK_LOG2-1];
  assign bclk = bclk_reg;
  assign lrck = lrck_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hc_reg       <= '0;
      bclk_reg     <= 1'b0;
      lrck_reg     <= 1'b0;
      bit_cnt_reg  <= '1;
      mclk_cnt_reg <= '0;
    end else begin
      mclk_cnt_reg <= mclk_cnt_reg + 1'b1;
      if (half_wrap) begin
        hc_reg   <= '0;
        bclk_reg <= ~bclk_reg;
      end else begin
        hc_reg <= hc_reg + 1'b1;
      end
      if (fall_stb) begin
        bit_cnt_reg <= bit_cnt_next;
        lrck_reg    <= (bit_cnt_next < BIT_CNT_W'(SLOT_BITS));
      end
    end
  end

endmodule

// File: rtl/i2s_master.sv
// I2S clock-master transceiver: drives the bus clocks, serializes a held
// stereo DAC frame onto sdout and deserializes sdin into stereo ADC samples.
module i2s_master
  import i2s_master_pkg::*;
#(
  parameter int HALF_DIV  = 16,
  parameter int MCLK_LOG2 = 3
) (
  input  logic                 AMSCK,
  input  logic                 rst_n,
  output logic                 mclk,
  output logic                 bclk,
  output logic                 lrck,
  output logic                 sdout,
  input  logic                 sdin,
  input  logic [DATA_BITS-1:0] tx_l,
  input  logic [DATA_BITS-1:0] tx_r,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_l,
  output logic [DATA_BITS-1:0] rx_r,
  output logic                 rx_valid,
  output logic                 underrun
);

  logic rise_stb;
  logic fall_stb;
  logic frame_start_stb;
  logic frame_end_stb;

  logic                  hold_full_reg;
  logic [DATA_BITS-1:0]  hold_l_reg;
  logic [DATA_BITS-1:0]  hold_r_reg;
  logic [FRAME_BITS-1:0] tx_sr_reg;
  logic [RX_KEEP-1:0]    rx_sr_reg;
  logic [DATA_BITS-1:0]  rx_l_reg;
  logic [DATA_BITS-1:0]  rx_r_reg;
  logic                  rx_valid_reg;
  logic                  underrun_reg;
  logic                  xfer;

  i2s_clkgen #(
    .HALF_DIV (HALF_DIV),
    .MCLK_LOG2(MCLK_LOG2)
  ) u_clkgen (
    .clk            (AMSCK),
    .rst_n          (rst_n),
    .mclk           (mclk),
    .bclk           (bclk),
    .lrck           (lrck),
    .rise_stb       (rise_stb),
    .fall_stb       (fall_stb),
    .frame_start_stb(frame_start_stb),
    .frame_end_stb  (frame_end_stb)
  );

  assign tx_ready = ~hold_full_reg;
  assign xfer     = tx_valid & ~hold_full_reg;
  assign sdout    = tx_sr_reg[FRAME_BITS-1];
  assign rx_l     = rx_l_reg;
  assign rx_r     = rx_r_reg;
  assign rx_valid = rx_valid_reg;
  assign underrun = underrun_reg;

  always_ff @(posedge AMSCK) begin
    if (!rst_n) begin
      hold_full_reg <= 1'b0;
      hold_l_reg    <= '0;
      hold_r_reg    <= '0;
      tx_sr_reg     <= '0;
      rx_sr_reg     <= '0;
      rx_l_reg      <= '0;
      rx_r_reg      <= '0;
      rx_valid_reg  <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      underrun_reg <= 1'b0;

      // Frame start looks at the pre-transfer holding state, so a transfer in
      // the same cycle lands in the holding register for the next frame.
      if (frame_start_stb) begin
        if (hold_full_reg) begin
          tx_sr_reg     <= pack_frame(hold_l_reg, hold_r_reg);
          hold_full_reg <= 1'b0;
        end else begin
          tx_sr_reg    <= '0;
          underrun_reg <= 1'b1;
        end
      end else if (fall_stb) begin
        tx_sr_reg <= {tx_sr_reg[FRAME_BITS-2:0], 1'b0};
      end

      if (xfer) begin
        hold_l_reg    <= tx_l;
        hold_r_reg    <= tx_r;
        hold_full_reg <= 1'b1;
      end

      if (rise_stb) begin
        rx_sr_reg <= {rx_sr_reg[RX_KEEP-2:0], sdin};
      end

      // The bit arriving on this last rise is the LSB of the right sample.
      if (frame_end_stb) begin
        rx_l_reg     <= rx_sr_reg[RX_KEEP-1 -: DATA_BITS];
        rx_r_reg     <= {rx_sr_reg[DATA_BITS-2:0], sdin};
        rx_valid_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_master.sv
// Directed bench: loops sdout back to sdin, runs a fixed schedule of frames
// and a mid-frame reset, checking clocks, frames and pulses per edge.
module tb_i2s_master;

  localparam int KMAX      = 16968;
  localparam int RST_EDGE  = 14868;
  localparam int NTRACE    = 7;

  logic        AMSCK = 1'b0;
  logic        rst_n = 1'b0;
  logic        mclk, bclk, lrck, sdout, sdin;
  logic [23:0] tx_l = '0;
  logic [23:0] tx_r = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [23:0] rx_l, rx_r;
  logic        rx_valid, underrun;

  assign sdin = sdout;

  always #5 AMSCK = ~AMSCK;

  i2s_master #(.HALF_DIV(16), .MCLK_LOG2(3)) dut (
    .AMSCK   (AMSCK),
    .rst_n   (rst_n),
    .mclk    (mclk),
    .bclk    (bclk),
    .lrck    (lrck),
    .sdout   (sdout),
    .sdin    (sdin),
    .tx_l    (tx_l),
    .tx_r    (tx_r),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_l    (rx_l),
    .rx_r    (rx_r),
    .rx_valid(rx_valid),
    .underrun(underrun)
  );

  typedef struct {
    logic [23:0] tl;
    logic [23:0] tr;
    logic        loaded;
    logic [63:0] frame;
    logic [23:0] el;
    logic [23:0] er;
  } frame_vec_t;

  typedef struct {
    int          edge_k;
    logic [23:0] l;
    logic [23:0] r;
  } wr_t;

  frame_vec_t fv[7];
  wr_t        wrs[7];
  int         rdy_lo[6];
  int         rdy_hi[6];

  int    total = 0;
  int    bad   = 0;
  int    terr[NTRACE];
  int    tfirst[NTRACE];
  logic  tact[NTRACE];
  logic  texp[NTRACE];
  string tname[NTRACE];

  int          base, ep, t, p, fi;
  logic        prev_sdout, rdy_exp, urun_exp, rxv_exp, loaded;
  logic [63:0] obs, frame_exp;
  logic [47:0] rx_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  function automatic void trace(input int id, input logic act, input logic e, input int k);
    if (act !== e) begin
      if (terr[id] == 0) begin
        tfirst[id] = k;
        tact[id]   = act;
        texp[id]   = e;
      end
      terr[id]++;
    end
  endfunction

  initial begin
    fv[0] = '{24'hABCDEF, 24'h123456, 1'b1, 64'h00ABCDEF_00123456, 24'hABCDEF, 24'h123456};
    fv[1] = '{24'hFFFFFF, 24'h000000, 1'b1, 64'h00FFFFFF_00000000, 24'hFFFFFF, 24'h000000};
    fv[2] = '{24'h000001, 24'h800000, 1'b1, 64'h00000001_00800000, 24'h000001, 24'h800000};
    fv[3] = '{24'h5A5A5A, 24'hA5A5A5, 1'b1, 64'h005A5A5A_00A5A5A5, 24'h5A5A5A, 24'hA5A5A5};
    fv[4] = '{24'h0,      24'h0,      1'b0, 64'h0,                 24'h0,      24'h0};
    fv[5] = '{24'h0,      24'h0,      1'b0, 64'h0,                 24'h0,      24'h0};
    fv[6] = '{24'h0,      24'h0,      1'b1, 64'h00000001_00800000, 24'h000001, 24'h800000};

    // Writes: three frames in advance, one ignored while full, one exactly at
    // the frame-5 start edge, and one just before the mid-frame reset.
    wrs[0] = '{1,     fv[0].tl, fv[0].tr};
    wrs[1] = '{132,   fv[1].tl, fv[1].tr};
    wrs[2] = '{500,   24'hCCCCCC, 24'hDDDDDD};
    wrs[3] = '{2180,  fv[2].tl, fv[2].tr};
    wrs[4] = '{4228,  fv[3].tl, fv[3].tr};
    wrs[5] = '{10272, 24'h000001, 24'h800000};
    wrs[6] = '{14468, 24'h777777, 24'h333333};

    rdy_lo = '{1, 132, 2180, 4228, 10272, 14468};
    rdy_hi = '{32, 2080, 4128, 6176, 12320, 14868};

    tname = '{"bclk", "lrck", "mclk", "rx_valid", "underrun", "tx_ready", "sdout_stable"};
    for (int i = 0; i < NTRACE; i++) begin
      terr[i] = 0; tfirst[i] = 0; tact[i] = 1'b0; texp[i] = 1'b0;
    end

    rst_n = 1'b0;
    repeat (3) begin
      @(posedge AMSCK);
      #1;
    end
    check("reset_flags", {57'd0, mclk, bclk, lrck, sdout, tx_ready, rx_valid, underrun},
          64'b0000100);
    check("reset_rx", {16'd0, rx_l, rx_r}, 64'd0);

    base = 0;
    ep = 0;
    prev_sdout = sdout;
    obs = '0;

    for (int k = 1; k <= KMAX; k++) begin
      rst_n    = (k != RST_EDGE);
      tx_valid = 1'b0;
      tx_l     = 24'h0F0F0F ^ 24'(k);
      tx_r     = ~tx_l;
      foreach (wrs[i]) begin
        if (wrs[i].edge_k == k) begin
          tx_valid = 1'b1;
          tx_l     = wrs[i].l;
          tx_r     = wrs[i].r;
        end
      end

      @(posedge AMSCK);
      #1;

      if (k == RST_EDGE) begin
        base = k;
        ep   = 1;
        check("midreset_flags", {57'd0, mclk, bclk, lrck, sdout, tx_ready, rx_valid, underrun},
              64'b0000100);
        check("midreset_rx", {16'd0, rx_l, rx_r}, 64'd0);
      end

      t  = k - base;
      p  = (t >= 32) ? (t - 32) % 2048 : -1;
      fi = (t >= 32) ? (t - 32) / 2048 : -1;
      loaded = (ep == 0 && fi >= 0 && fi < 7) ? fv[fi].loaded : 1'b0;

      rdy_exp = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (k >= rdy_lo[i] && k < rdy_hi[i]) rdy_exp = 1'b0;
      end
      urun_exp = (p == 0) && !loaded;
      rxv_exp  = (t == 16) || (p == 2032);

      trace(0, bclk, ((t / 16) % 2) == 1, k);
      trace(1, lrck, (p >= 0) && (p < 1024), k);
      trace(2, mclk, (t % 8) >= 4, k);
      trace(3, rx_valid, rxv_exp, k);
      trace(4, underrun, urun_exp, k);
      trace(5, tx_ready, rdy_exp, k);
      if (t != 0 && !(p >= 0 && (p % 32) == 0)) trace(6, sdout, prev_sdout, k);
      prev_sdout = sdout;

      if (p >= 0 && (p % 32) == 16) obs[63 - p / 32] = sdout;

      if (rxv_exp) begin
        if (t == 16) begin
          rx_exp = '0;
        end else if (ep == 0 && fi < 7) begin
          rx_exp = {fv[fi].el, fv[fi].er};
        end else begin
          rx_exp = '0;
        end
        check($sformatf("rx_e%0d_t%0d", ep, t), {16'd0, rx_l, rx_r}, {16'd0, rx_exp});
      end

      if (p == 2032) begin
        frame_exp = (ep == 0 && fi < 7) ? fv[fi].frame : 64'd0;
        check($sformatf("sdout_frame_e%0d_f%0d", ep, fi), obs, frame_exp);
      end
    end

    for (int i = 0; i < NTRACE; i++) begin
      total++;
      if (terr[i] != 0) begin
        bad++;
        $display("FAIL trace_%s: %0d bad edges, first at edge %0d got %0b want %0b",
                 tname[i], terr[i], tfirst[i], tact[i], texp[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_master.md
Name: i2s_master

Overview:
- I2S clock-master transceiver: generates MCLK, BCLK and LRCK from AMSCK.
- Serializes stereo 24-bit DAC frames onto sdout and deserializes sdin into stereo 24-bit ADC frames.
- It is the opposite end of the codec-slave I2S interface: it drives the clocks that interface receives.
- Uses: codec-less loopback, clocking an external slave DAC/ADC, and the bench model for the slave interface.

Parameters:
- HALF_DIV, 16: AMSCK cycles per BCLK half-period. Must be ≥ 2. At 98.304 MHz this gives BCLK = 3.072 MHz, fs = 48 kHz.
- MCLK_LOG2, 3: MCLK = AMSCK / 2^MCLK_LOG2, free-running counter MSB.

Ports:
- AMSCK  in  1  system clock, 98.304 MHz; the single clock.
- rst_n  in  1  synchronous, active-low reset.
- mclk  out  1  codec master clock.
- bclk  out  1  bit clock.
- lrck  out  1  frame clock; 1 = left slot, 0 = right slot.
- sdout  out  1  serial data to slave DAC.
- sdin  in  1  serial data from slave ADC.
- tx_l  in  24  left DAC sample.
- tx_r  in  24  right DAC sample.
- tx_valid  in  1  tx frame offered.
- tx_ready  out  1  holding register empty.
- rx_l  out  24  left ADC sample.
- rx_r  out  24  right ADC sample.
- rx_valid  out  1  one-cycle pulse; rx_l/rx_r updated this cycle.
- underrun  out  1  one-cycle pulse; frame started with no tx data.

Behaviour:
- Interface: one clock (AMSCK); reset is synchronous and active-low (rst_n).
- Reset values: mclk=0, bclk=0, lrck=0, sdout=0, tx_ready=1, rx_l=0, rx_r=0, rx_valid=0, underrun=0.
  - Internal state at reset: half-counter hc=0, bit_cnt=63, mclk counter=0, holding register empty.
- Clocking:
  - hc counts 0..HALF_DIV-1. On hc==HALF_DIV-1, hc wraps and bclk toggles.
  - rise event: toggle 0→1. fall event: toggle 1→0.
  - BCLK period = 2·HALF_DIV AMSCK cycles, 50% duty.
- Frame:
  - 64 BCLK per frame. bit_cnt increments mod 64 on each fall.
  - lrck is registered on fall as (new bit_cnt < 32).
  - The first fall after reset gives bit_cnt=0, lrck=1, i.e. the left slot starts.
- Slot format: right-justified, MSB first. Each 32-bit slot is 8 zero bits followed by 24 data bits. No one-bit I2S delay.
- TX:
  - On the fall where bit_cnt wraps 63→0 (frame start), the 64-bit shift register loads {8'd0, L, 8'd0, R} and sdout takes bit 63.
  - On every other fall, shift left, zero fill.
  - sdout changes only on fall.
  - Loaded frame source:
    - Holding register full: load from the holding register, which then empties; tx_ready=1 the next cycle.
    - Holding register empty: load all zeros and pulse underrun for 1 cycle.
- TX handshake:
  - Transfer occurs when tx_valid && tx_ready.
  - Holding register captures tx_l/tx_r; tx_ready=0 the next cycle.
  - tx_l/tx_r need only be stable in the transfer cycle.
- Simultaneous transfer and frame start in the same cycle: the frame start sees the pre-transfer (empty) state. Result: zeros sent, underrun pulsed, the new data is kept and used at the next frame start.
- RX:
  - On each rise, shift sdin into a 64-bit shift register (LSB in).
  - On the rise with bit_cnt==63, register rx_l = received bits 8..31 of the left slot and rx_r = bits 40..63 of the frame (incoming bit included). rx_valid=1 in that same cycle, 0 otherwise.
  - The partial frame after reset is not discarded specially; the first rx_valid carries whatever was sampled.
- mclk: free-running, independent of bit/frame state.
- Reset mid-operation: all state returns to reset values next cycle. Holding register data is dropped; no underrun or rx_valid pulse is generated by reset.

Decomposition:
- Shared header i2s_defs.vh with constants:
  - SLOT_BITS=32, DATA_BITS=24, PAD_BITS=8, FRAME_BITS=64.
  - Also used by the existing slave interface.
- One sub-module, i2s_clkgen:
  - Contains hc, bclk, bit_cnt, lrck, mclk.
  - Outputs rise_stb, fall_stb, frame_start_stb, frame_end_stb.
- The top level holds the TX/RX shift registers and the handshake.

Test Plan:
- Reset then run: bclk period exactly 32 AMSCK cycles. lrck high for 1024 and low for 1024 cycles. First lrck rise coincides with the first bclk fall. mclk period 8 cycles.
- tx_l=0xABCDEF, tx_r=0x123456 accepted before frame start. sdout over the frame is:
  - 8 zeros, 1010_1011_1100_1101_1110_1111 (left slot),
  - 8 zeros, 0001_0010_0011_0100_0101_0110 (right slot).
- Loopback sdout→sdin with frames written continuously. The rx_valid pulse at the end of the transmitting frame yields rx_l=0xABCDEF, rx_r=0x123456. Exactly one rx_valid per 2048 cycles.
- tx_valid=0 at frame start: underrun pulses once, sdout all zero for the frame, tx_ready stays 1.
- tx_valid asserted in exactly the frame-start cycle with 0x000001/0x800000: underrun pulses, current frame is zeros, next frame carries the values, tx_ready=0 until that next frame start.
- rst_n low for 1 cycle mid-left-slot with holding register full:
  - Outputs return to reset values and tx_ready=1.
  - The next frame starts after 16+16 cycles (first rise, then first fall).
  - No spurious rx_valid or underrun pulse.
